// File: rtl/display_reader_if.sv
// Request/response and panel-bus signals of the display read engine.
// master = requester and panel model, slave = the reader itself.
interface display_reader_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              rdReq;
  logic              rdRs;
  logic [CNT_W-1:0]  rdCount;
  logic [DATA_W-1:0] lcdDataIn;
  logic              lcdCs;
  logic              lcdRs;
  logic              lcdRd;
  logic              lcdWr;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic              busy;
  logic              done;

  modport master (
    output rdReq, rdRs, rdCount, lcdDataIn,
    input  lcdCs, lcdRs, lcdRd, lcdWr, rdData, rdValid, busy, done
  );

  modport slave (
    input  rdReq, rdRs, rdCount, lcdDataIn,
    output lcdCs, lcdRs, lcdRd, lcdWr, rdData, rdValid, busy, done
  );
endinterface

// File: rtl/display_reader.sv
// Parallel-bus display read engine: issues RD strobes (optionally one dummy
// first) and returns the sampled bytes with a valid pulse per byte.
module display_reader #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 3,
  parameter int RD_LOW   = 2,
  parameter int RD_HIGH  = 1,
  parameter int DUMMY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  display_reader_if.slave  bus
);
  localparam int SW = CNT_W + 1;
  localparam logic [3:0] LO_LAST = 4'(RD_LOW - 1);
  localparam logic [3:0] HI_LAST = 4'(RD_HIGH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, RD_LO, RD_HI, HOLD} state_e;

  state_e            state_q, state_d;
  logic              req_prev_q;
  logic [3:0]        phase_q, phase_d;
  logic [SW-1:0]     rem_q, rem_d;
  logic              dummy_q, dummy_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic [SW-1:0]     total;

  // Strobe count for the request: a zero count means the full 2^CNT_W bytes.
  always_comb begin
    total = (bus.rdCount == '0) ? (SW'(1) << CNT_W) : SW'(bus.rdCount);
    total = total + SW'(DUMMY_EN != 0);
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    dummy_d = dummy_q;
    rs_d    = rs_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rdReq && !req_prev_q) begin
          state_d = SETUP;
          rs_d    = bus.rdRs;
          rem_d   = total;
          dummy_d = (DUMMY_EN != 0);
          phase_d = '0;
        end
      end
      SETUP: begin
        state_d = RD_LO;
        phase_d = '0;
      end
      RD_LO: begin
        if (phase_q == LO_LAST) begin
          state_d = RD_HI;
          phase_d = '0;
          rem_d   = rem_q - SW'(1);
          dummy_d = 1'b0;
          // The dummy strobe only primes the panel; its byte is discarded.
          if (!dummy_q) begin
            data_d  = bus.lcdDataIn;
            valid_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      RD_HI: begin
        if (phase_q == HI_LAST) begin
          phase_d = '0;
          state_d = (rem_q != '0) ? RD_LO : HOLD;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    cs_d   = !busy_d;
    rd_d   = (state_d != RD_LO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      phase_q    <= '0;
      rem_q      <= '0;
      dummy_q    <= 1'b0;
      rs_q       <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_prev_q <= bus.rdReq;
      phase_q    <= phase_d;
      rem_q      <= rem_d;
      dummy_q    <= dummy_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.lcdCs   = cs_q;
  assign bus.lcdRs   = rs_q;
  assign bus.lcdRd   = rd_q;
  assign bus.lcdWr   = 1'b1;
  assign bus.rdData  = data_q;
  assign bus.rdValid = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
